// File: rtl/shift_reg_sequencer_pkg.sv
// shift_reg_sequencer_pkg: op and FSM state encodings shared by the sequencer and its shift register.
package shift_reg_sequencer_pkg;
    typedef logic [1:0] op_t;
    localparam op_t OP_NOP  = 2'b00;
    localparam op_t OP_SHL  = 2'b01;
    localparam op_t OP_SHR  = 2'b10;
    localparam op_t OP_LOAD = 2'b11;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
endpackage

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: N-bit register with hold, shift left/right (serial bit from D) and parallel load.
module univ_shift_reg
    import shift_reg_sequencer_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         n_reset,
    input  op_t          ctrl,
    input  logic [N-1:0] D,
    output logic [N-1:0] Q
);
    logic [N-1:0] q_q, q_d;

    always_comb begin
        q_d = ctrl == OP_SHL  ? {q_q[N-2:0], D[0]} :
              ctrl == OP_SHR  ? {D[N-1], q_q[N-1:1]} :
              ctrl == OP_LOAD ? D : q_q;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) q_q <= '0;
        else          q_q <= q_d;
    end

    assign Q = q_q;
endmodule

// File: rtl/shift_reg_sequencer.sv
// shift_reg_sequencer: accepts one load/shift/nop command at a time, sequences the
// shift register through it cycle by cycle, then returns the result over a response handshake.
module shift_reg_sequencer
    import shift_reg_sequencer_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = $clog2(N+1)
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [CW-1:0] cmd_amount,
    input  logic          cmd_fill,
    input  logic [N-1:0]  cmd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [N-1:0]  rsp_data,
    output logic [N-1:0]  q,
    output logic          busy
);
    logic [1:0]    state_q, state_d;
    op_t           op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fill_q, fill_d;
    logic [N-1:0]  data_q, data_d;
    logic [CW-1:0] amt_clamped;
    logic          is_shift;
    op_t           ctrl;
    logic [N-1:0]  reg_d;

    assign amt_clamped = cmd_amount > CW'(N) ? CW'(N) : cmd_amount;
    assign is_shift    = cmd_op == OP_SHL || cmd_op == OP_SHR;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        data_d  = data_q;
        if (state_q == ST_IDLE && cmd_valid) begin
            op_d    = cmd_op;
            fill_d  = cmd_fill;
            data_d  = cmd_data;
            cnt_d   = cmd_op == OP_LOAD ? CW'(1) : amt_clamped;
            // Nops and zero-amount shifts skip EXEC so the register is never touched.
            state_d = (cmd_op == OP_LOAD || (is_shift && amt_clamped != '0)) ? ST_EXEC : ST_RESP;
        end else if (state_q == ST_EXEC) begin
            cnt_d   = cnt_q - CW'(1);
            state_d = cnt_q == CW'(1) ? ST_RESP : ST_EXEC;
        end else if (state_q == ST_RESP && rsp_ready) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            cnt_q   <= '0;
            fill_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
        end
    end

    assign ctrl  = state_q == ST_EXEC ? op_q : OP_NOP;
    assign reg_d = op_q == OP_LOAD ? data_q : {N{fill_q}};

    univ_shift_reg #(.N(N)) u_reg (
        .clk     (clk),
        .n_reset (n_reset),
        .ctrl    (ctrl),
        .D       (reg_d),
        .Q       (q)
    );

    assign cmd_ready = state_q == ST_IDLE;
    assign busy      = state_q != ST_IDLE;
    assign rsp_valid = state_q == ST_RESP;
    assign rsp_data  = q;
endmodule

// File: tb/tb_shift_reg_sequencer.sv
// tb_shift_reg_sequencer: directed command vectors with hand-computed results and latencies,
// plus hand-written stepping, backpressure and mid-command reset sequences.
module tb_shift_reg_sequencer;
    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_amount = 4'd0;
    logic       cmd_fill = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic [7:0] q;
    logic       busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shift_reg_sequencer dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_amount (cmd_amount),
        .cmd_fill   (cmd_fill),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .q          (q),
        .busy       (busy)
    );

    typedef struct {
        logic [1:0] op;
        logic [3:0] amt;
        logic       fill;
        logic [7:0] data;
        logic [7:0] exp;
        int         lat;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic offer(input logic [1:0] op, input logic [3:0] amt, input logic fill, input logic [7:0] data);
        @(negedge clk);
        cmd_op = op;
        cmd_amount = amt;
        cmd_fill = fill;
        cmd_data = data;
        cmd_valid = 1'b1;
        chk("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic wait_rsp(input string name, input logic [7:0] exp, input int lat);
        int n = 0;
        bit seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (rsp_valid) seen = 1;
            else chk({name, "_busy"}, {31'd0, busy}, 1);
        end
        chk({name, "_latency"}, n, lat);
        chk({name, "_rsp_data"}, rsp_data, exp);
        chk({name, "_q"}, q, exp);
        take_rsp();
    endtask

    initial begin
        vecs[0]  = '{2'b11, 4'd0,  1'b0, 8'hA5, 8'hA5, 2};
        vecs[1]  = '{2'b01, 4'd3,  1'b1, 8'h00, 8'h2F, 4};
        vecs[2]  = '{2'b10, 4'd2,  1'b0, 8'hFF, 8'h0B, 3};
        vecs[3]  = '{2'b00, 4'd5,  1'b1, 8'h77, 8'h0B, 1};
        vecs[4]  = '{2'b10, 4'd12, 1'b1, 8'h00, 8'hFF, 9};
        vecs[5]  = '{2'b01, 4'd0,  1'b0, 8'h00, 8'hFF, 1};
        vecs[6]  = '{2'b11, 4'd7,  1'b1, 8'h3C, 8'h3C, 2};
        vecs[7]  = '{2'b01, 4'd8,  1'b0, 8'hFF, 8'h00, 9};
        vecs[8]  = '{2'b11, 4'd0,  1'b0, 8'h81, 8'h81, 2};
        vecs[9]  = '{2'b10, 4'd1,  1'b1, 8'h00, 8'hC0, 2};
        vecs[10] = '{2'b01, 4'd15, 1'b1, 8'h00, 8'hFF, 9};

        #1;
        chk("rst_q", q, 8'h00);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        n_reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            offer(vecs[i].op, vecs[i].amt, vecs[i].fill, vecs[i].data);
            wait_rsp($sformatf("vec%0d", i), vecs[i].exp, vecs[i].lat);
        end

        // q stepping through a 3-position left shift
        offer(2'b11, 4'd0, 1'b0, 8'hA5);
        wait_rsp("reload", 8'hA5, 2);
        offer(2'b01, 4'd3, 1'b1, 8'h00);
        @(negedge clk);
        chk("step1_q", q, 8'hA5);
        chk("step1_cmd_ready", cmd_ready, 0);
        @(negedge clk);
        chk("step2_q", q, 8'h4B);
        @(negedge clk);
        chk("step3_q", q, 8'h97);
        chk("step3_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        chk("step4_q", q, 8'h2F);
        chk("step4_rsp_valid", rsp_valid, 1);
        chk("step4_rsp_data", rsp_data, 8'h2F);
        take_rsp();

        // backpressure in RESP while a new command is held
        offer(2'b10, 4'd2, 1'b0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("bp_enter", rsp_valid, 1);
        cmd_op = 2'b11;
        cmd_data = 8'h55;
        cmd_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_data", rsp_data, 8'h0B);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_q", q, 8'h0B);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_after_cmd_ready", cmd_ready, 1);
        chk("bp_after_rsp_valid", rsp_valid, 0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("bp_accept_busy", busy, 1);
        chk("bp_accept_cmd_ready", cmd_ready, 0);
        @(negedge clk);
        chk("bp_load_rsp_valid", rsp_valid, 1);
        chk("bp_load_rsp_data", rsp_data, 8'h55);
        take_rsp();

        // reset during the second EXEC cycle of a 6-position shift
        offer(2'b01, 4'd6, 1'b1, 8'h00);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_q", q, 8'hAB);
        n_reset = 1'b0;
        #1;
        chk("abort_q", q, 8'h00);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        n_reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", rsp_valid, 0);
            chk("post_rst_q", q, 8'h00);
        end
        offer(2'b11, 4'd0, 1'b0, 8'h12);
        wait_rsp("post_rst_load", 8'h12, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/shift_reg_sequencer.md
Name: shift_reg_sequencer

Overview:
Command-driven controller that owns one N-bit universal shift register and sequences it through multi-cycle operations. It accepts one command at a time over a valid/ready handshake: parallel load, multi-position left shift, or multi-position right shift with a selectable fill bit. On completion it returns the resulting register word over a second valid/ready handshake. It sits between a host or bus-side requester and the shift datapath, so requesters never drive the per-cycle register control directly.

Parameters:
N, 8, register width in bits; N >= 2.
CW, $clog2(N+1), width of the shift-amount field.

Ports:
clk  input  1  rising-edge clock
n_reset  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  2  00 nop, 01 shift left, 10 shift right, 11 parallel load
cmd_amount  input  CW  number of positions to shift; ignored for load and nop
cmd_fill  input  1  serial bit shifted in on each shift cycle
cmd_data  input  N  load word, used only when cmd_op = 11
rsp_valid  output  1  result available
rsp_ready  input  1  requester accepts the result
rsp_data  output  N  register contents when the command completed
q  output  N  live register contents
busy  output  1  high whenever state is not IDLE

Behaviour:
- One clock; reset is asynchronous and active-low. Clock port is clk, reset port is n_reset.
- Reset values: state IDLE, register 0, q 0, rsp_data 0, rsp_valid 0, busy 0, cmd_ready 1. Internal captured op, count and fill are all 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready = 1 and register ctrl = 00 (hold).
  - A command is accepted when cmd_valid and cmd_ready are both high. On acceptance, capture op, fill, data and cnt.
  - cnt = min(cmd_amount, N); amounts greater than N clamp to N.
  - op = 11 -> go to EXEC with cnt forced to 1.
  - op = 01 or 10 with cnt >= 1 -> go to EXEC.
  - op = 00, or a shift with cnt = 0 -> go directly to RESP; the register is unchanged.
- EXEC:
  - cmd_ready = 0. Register ctrl = captured op.
  - Register D = captured data for a load, otherwise {N{fill}}. Shift left inserts at bit 0 and drops bit N-1; shift right inserts at bit N-1 and drops bit 0.
  - cnt decrements by 1 each cycle. When cnt = 1, the next state is RESP.
- RESP:
  - ctrl = 00, so the register holds. rsp_valid = 1 and rsp_data = q, both stable until rsp_ready is sampled high.
  - On rsp_valid and rsp_ready both high, return to IDLE.
  - A new command is not accepted in the same cycle as the response handshake; earliest acceptance is the following cycle.
- Latency, where T is the acceptance cycle:
  - Load: rsp_valid first asserts in cycle T+2.
  - Shift by k (after clamping): rsp_valid first asserts in cycle T+1+k.
  - Nop or zero-amount shift: rsp_valid first asserts in cycle T+1.
- Commands are never queued. While cmd_ready = 0, cmd_* inputs are ignored; the requester must hold its command.
- The register changes only in EXEC, so q is stable in IDLE and RESP.
- Reset asserted mid-command: immediate abort, all state and outputs return to reset values, no response is produced. After n_reset deasserts, the first rising edge may accept a command.
- Illegal or unknown op values do not exist; all four 2-bit encodings are defined.

Decomposition:
- Shared package holds:
  - Op encoding constants OP_NOP = 2'b00, OP_SHL = 2'b01, OP_SHR = 2'b10, OP_LOAD = 2'b11, identical to the register's ctrl encoding.
  - FSM state encoding ST_IDLE, ST_EXEC, ST_RESP.
- One sub-module: univ_shift_reg (parameter N, ports clk, n_reset, ctrl, D, Q), instantiated once.
- The sequencer contains only the FSM, the counter and the captured command registers.

Test Plan:
- After reset, load 0xA5 (N = 8) -> q = 0xA5; rsp_valid rises in T+2 with rsp_data = 0xA5; cmd_ready is 0 in T+1 and T+2.
- From 0xA5, shift left, amount 3, fill 1 -> q steps 0x4B, 0x97, 0x2F; rsp_data = 0x2F with rsp_valid in T+4.
- From 0x2F, shift right, amount 2, fill 0 -> rsp_data = 0x0B in T+3. Then nop -> rsp_data = 0x0B in T+1 with q unchanged.
- Shift right, amount 12 (clamped to 8), fill 1, from 0x0B -> exactly 8 EXEC cycles; rsp_data = 0xFF in T+9.
- Hold rsp_ready low for 5 cycles in RESP while cmd_valid is held high -> rsp_valid and rsp_data stay stable, cmd_ready stays 0, q does not change; after the handshake, the command is accepted one cycle later.
- Pull n_reset low during cycle 2 of an amount-6 shift -> q = 0, rsp_valid = 0, busy = 0 immediately, and no response is emitted after release.
